// File: rtl/uart_hex_loader_pkg.sv
// uart_hex_loader_pkg: parser states, ASCII constants and character classification for the hex boot loader
package uart_hex_loader_pkg;
   typedef enum logic [2:0] {S_SKIP, S_WORD, S_ADDR, S_WRITE, S_DONE} state_t;
   typedef enum logic [2:0] {C_HEX, C_WS, C_AT, C_END, C_BAD} char_class_t;
   localparam logic [7:0] CH_AT   = 8'h40;
   localparam logic [7:0] CH_BANG = 8'h21;
   localparam logic [7:0] CH_CR   = 8'h0d;
   localparam logic [7:0] CH_LF   = 8'h0a;
   localparam logic [7:0] CH_SP   = 8'h20;
   localparam logic [7:0] CH_TAB  = 8'h09;
   // returns {is_hex, nibble}; letters share low nibble 1..6 in both cases
   function automatic logic [4:0] hex_val(input logic [7:0] c);
      return (c >= "0" && c <= "9") ? {1'b1, c[3:0]} :
             ((c >= "a" && c <= "f") || (c >= "A" && c <= "F")) ? {1'b1, c[3:0] + 4'd9} : 5'd0;
   endfunction
   function automatic char_class_t char_class(input logic [7:0] c);
      logic [4:0] h;
      h = hex_val(c);
      return h[4] ? C_HEX :
             (c == CH_SP || c == CH_TAB || c == CH_CR || c == CH_LF) ? C_WS :
             c == CH_AT ? C_AT : c == CH_BANG ? C_END : C_BAD;
   endfunction
endpackage

// File: rtl/uart_hex_loader_skid.sv
// uart_hex_loader_skid: one-byte holding register between the UART and the parser; flags bytes that find it full
module uart_hex_loader_skid
   import uart_hex_loader_pkg::*;
(
   input  logic       clk,
   input  logic       resetb,
   input  logic       clear,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       take,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       overrun
);
   logic       full;
   logic [7:0] hold;
   assign out_valid = full | in_valid;
   assign out_data  = full ? hold : in_data;
   assign overrun   = full & in_valid & ~take & ~clear;
   always_ff @(posedge clk or negedge resetb)
      if (!resetb) begin
         full <= 1'b0;
         hold <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else begin
         if (in_valid && (full ? take : !take)) hold <= in_data;
         full <= in_valid ? (full | ~take) : (full & ~take);
      end
endmodule

// File: rtl/uart_hex_loader.sv
// uart_hex_loader: parses an ASCII hex word stream into 32-bit RAM writes, holding the core in reset until '!'
module uart_hex_loader
  import uart_hex_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              load_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              core_resetb,
  output logic [ADDR_W:0]   word_cnt,
  output logic              err_digits,
  output logic              err_char,
  output logic              err_overrun
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  state_t      state;
  char_class_t cls;
  logic [31:0] acc;
  logic [3:0]  ndig, digit;
  logic [7:0]  b_data;
  logic        done_pend, b_valid, overrun, go;
  uart_hex_loader_skid u_skid (
    .clk,
    .resetb,
    .clear(load_start),
    .in_valid(rx_valid),
    .in_data(rx_data),
    .take(state != S_WRITE),
    .out_valid(b_valid),
    .out_data(b_data),
    .overrun
  );
  assign cls   = char_class(b_data);
  assign digit = 4'(hex_val(b_data));
  assign go    = b_valid && state != S_WRITE;
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      state       <= S_SKIP;
      acc         <= '0;
      ndig        <= '0;
      done_pend   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= BASE;
      mem_wdata   <= '0;
      word_cnt    <= '0;
      busy        <= 1'b1;
      core_resetb <= 1'b0;
      err_digits  <= 1'b0;
      err_char    <= 1'b0;
      err_overrun <= 1'b0;
    end else if (load_start) begin
      state       <= S_SKIP;
      done_pend   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= BASE;
      word_cnt    <= '0;
      busy        <= 1'b1;
      core_resetb <= 1'b0;
      err_digits  <= 1'b0;
      err_char    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (overrun) err_overrun <= 1'b1;
      if (go && cls == C_BAD && state != S_DONE) err_char <= 1'b1;
      case (state)
        S_SKIP: if (go) begin
          if (cls == C_HEX) begin
            acc   <= {28'd0, digit};
            ndig  <= 4'd1;
            state <= S_WORD;
          end else if (cls == C_AT) begin
            acc   <= '0;
            ndig  <= '0;
            state <= S_ADDR;
          end else if (cls == C_END) begin
            state <= S_DONE;
          end
        end
        S_WORD, S_ADDR: if (go) begin
          if (cls == C_HEX) begin
            if (ndig == 4'd8) err_digits <= 1'b1;
            else begin
              acc  <= {acc[27:0], digit};
              ndig <= ndig + 4'd1;
            end
          end else if (state == S_WORD) begin
            mem_we    <= 1'b1;
            mem_wdata <= acc;
            done_pend <= cls == C_END;
            state     <= S_WRITE;
          end else begin
            mem_addr <= acc[ADDR_W-1:0];
            state    <= cls == C_END ? S_DONE : S_SKIP;
          end
        end
        S_WRITE: if (mem_ready) begin
          mem_we   <= 1'b0;
          mem_addr <= mem_addr + ADDR_W'(1);
          if (word_cnt != '1) word_cnt <= word_cnt + (ADDR_W+1)'(1);
          state    <= done_pend ? S_DONE : S_SKIP;
        end
        default: begin
          busy        <= 1'b0;
          core_resetb <= 1'b1;
        end
      endcase
    end
endmodule
